// File: rtl/l1a_bxn_reader_pkg.sv
// Shared types and constants for the L1A bunch-crossing FIFO read side.
package l1a_bxn_pkg;

  localparam int unsigned BXN_W = 12;
  localparam logic [BXN_W-1:0] MISSING_BXN = 12'hFFF;
  localparam logic [BXN_W-1:0] BXN_MAX     = 12'd3563;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    WAIT = 3'd1,
    POP  = 3'd2,
    CAPT = 3'd3,
    HOLD = 3'd4
  } state_t;

endpackage

// File: rtl/l1a_bxn_reader_if.sv
// Valid/ack handshake carrying one BXN to the DAQ header builder.
interface l1a_bxn_reader_if;
  import l1a_bxn_pkg::*;

  logic [BXN_W-1:0] bxn_out;
  logic             bxn_valid;
  logic             bxn_missing;
  logic             bxn_ack;

  modport master (output bxn_out, output bxn_valid, output bxn_missing, input bxn_ack);
  modport slave  (input bxn_out, input bxn_valid, input bxn_missing, output bxn_ack);

endinterface

// File: rtl/l1a_bxn_reader_req_counter.sv
// Saturating up/down count of outstanding readout requests with sticky overflow.
module l1a_req_counter #(
  parameter int unsigned PEND_W = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              inc,
  input  logic              dec,
  output logic [PEND_W-1:0] count,
  output logic              ovf
);

  localparam logic [PEND_W-1:0] CNT_MAX = '1;

  // Simultaneous inc and dec cancel; a saturated increment is dropped and flagged.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count <= '0;
      ovf   <= 1'b0;
    end else if (inc && !dec) begin
      if (count == CNT_MAX) ovf <= 1'b1;
      else                  count <= count + PEND_W'(1);
    end else if (dec && !inc && (count != '0)) begin
      count <= count - PEND_W'(1);
    end
  end

endmodule

// File: rtl/l1a_bxn_reader.sv
// Pops one BXN per readout request and hands it to the header builder,
// substituting MISSING_BXN on timeout. Optional range check: L1A_BXN_CHECK_EN.
module l1a_bxn_reader
  import l1a_bxn_pkg::*;
#(
  parameter int unsigned TIMEOUT = 16,
  parameter int unsigned PEND_W  = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             rd_req,
  input  logic [BXN_W-1:0] fifo_dout,
  input  logic             fifo_empty,
  output logic             fifo_ren,
  l1a_bxn_reader_if.master bxn,
  output logic             pend_ovf
`ifdef L1A_BXN_CHECK_EN
  ,
  output logic             bxn_range_err
`endif
);

  localparam int unsigned TMR_W = 8;
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT - 1);

  state_t             state, state_d;
  logic [TMR_W-1:0]   timer, timer_d;
  logic [PEND_W-1:0]  pending;
  logic               dec;
  logic               ren_d;
  logic [BXN_W-1:0]   bxn_out_q, bxn_out_d;
  logic               valid_q, valid_d;
  logic               missing_q, missing_d;

  l1a_req_counter #(.PEND_W(PEND_W)) u_req_counter (
    .clk     (clk),
    .reset_n (reset_n),
    .inc     (rd_req),
    .dec     (dec),
    .count   (pending),
    .ovf     (pend_ovf)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      timer     <= '0;
      fifo_ren  <= 1'b0;
      bxn_out_q <= '0;
      valid_q   <= 1'b0;
      missing_q <= 1'b0;
    end else begin
      state     <= state_d;
      timer     <= timer_d;
      fifo_ren  <= ren_d;
      bxn_out_q <= bxn_out_d;
      valid_q   <= valid_d;
      missing_q <= missing_d;
    end
  end

  // Next state; an arrival on the final WAIT cycle still wins over the timeout.
  always_comb begin
    state_d   = state;
    timer_d   = timer;
    dec       = 1'b0;
    bxn_out_d = bxn_out_q;
    valid_d   = valid_q;
    missing_d = missing_q;
    unique case (state)
      IDLE: begin
        if (pending != '0) begin
          if (!fifo_empty) begin
            state_d = POP;
          end else begin
            state_d = WAIT;
            timer_d = '0;
          end
        end
      end
      WAIT: begin
        if (!fifo_empty) begin
          state_d = POP;
        end else if (timer == TMR_LAST) begin
          bxn_out_d = MISSING_BXN;
          valid_d   = 1'b1;
          missing_d = 1'b1;
          dec       = 1'b1;
          state_d   = HOLD;
        end else begin
          timer_d = timer + TMR_W'(1);
        end
      end
      POP: begin
        dec     = 1'b1;
        state_d = CAPT;
      end
      CAPT: begin
        bxn_out_d = fifo_dout;
        valid_d   = 1'b1;
        missing_d = 1'b0;
        state_d   = HOLD;
      end
      HOLD: begin
        if (bxn.bxn_ack) begin
          valid_d   = 1'b0;
          missing_d = 1'b0;
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    ren_d = (state_d == POP);
  end

  assign bxn.bxn_out     = bxn_out_q;
  assign bxn.bxn_valid   = valid_q;
  assign bxn.bxn_missing = missing_q;

`ifdef L1A_BXN_CHECK_EN
  // Out-of-range captures are flagged but forwarded untouched.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bxn_range_err <= 1'b0;
    end else if ((state == CAPT) && (fifo_dout > BXN_MAX)) begin
      bxn_range_err <= 1'b1;
    end
  end
`endif

endmodule
